// File: rtl/alarm_clock_pkg.sv
// Shared encodings and BCD helper for the alarm clock core.
package alarm_clock_pkg;

    localparam logic [2:0] SF_RUN   = 3'd0;
    localparam logic [2:0] SF_T_HR  = 3'd1;
    localparam logic [2:0] SF_T_MIN = 3'd2;
    localparam logic [2:0] SF_A_HR  = 3'd3;
    localparam logic [2:0] SF_A_MIN = 3'd4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RING   = 2'd1,
        ST_SNOOZE = 2'd2
    } ring_state_t;

    // Increment a two-digit BCD value, returning min_val after max_val.
    function automatic logic [7:0] bcd_inc_wrap(input logic [7:0] val,
                                                input logic [7:0] max_val,
                                                input logic [7:0] min_val);
        if (val == max_val)
            return min_val;
        if (val[3:0] == 4'd9)
            return {val[7:4] + 4'd1, 4'd0};
        return {val[7:4], val[3:0] + 4'd1};
    endfunction

endpackage

// File: rtl/alarm_clock_core_bcd_mod_counter.sv
// Two-digit BCD counter with load, wrapping increment and carry out.
module bcd_mod_counter
    import alarm_clock_pkg::*;
#(
    parameter logic [3:0] MAX_TENS  = 4'd5,
    parameter logic [3:0] MAX_UNITS = 4'd9,
    parameter logic [7:0] MIN_VAL   = 8'h00,
    parameter logic [7:0] RST_VAL   = 8'h00
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic [7:0] load_val,
    input  logic       inc,
    output logic [7:0] q,
    output logic [7:0] nxt,
    output logic       carry
);

    localparam logic [7:0] MAX_VAL = {MAX_TENS, MAX_UNITS};

    assign nxt   = bcd_inc_wrap(q, MAX_VAL, MIN_VAL);
    assign carry = inc && (q == MAX_VAL);

    always_ff @(posedge clk) begin
        if (!rst_n)
            q <= RST_VAL;
        else if (load)
            q <= load_val;
        else if (inc)
            q <= nxt;
    end

endmodule

// File: rtl/alarm_clock_core.sv
// HH:MM:SS timekeeper with NUM_ALARMS alarm slots, set mode and ring/snooze FSM.
//
//  state     | meaning
//  ST_IDLE   | waiting for an enabled alarm to match
//  ST_RING   | beeper on, counting ring seconds toward auto-stop
//  ST_SNOOZE | beeper off, counting down snooze seconds before re-ringing
module alarm_clock_core
    import alarm_clock_pkg::*;
#(
    parameter int TICK_DIV   = 100_000_000,
    parameter int NUM_ALARMS = 2,
    parameter int HOUR_24    = 1,
    parameter int RING_SECS  = 60,
    parameter int SNOOZE_MIN = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  run,
    input  logic [2:0]            set_field,
    input  logic                  inc,
    input  logic [2:0]            alarm_sel,
    input  logic [NUM_ALARMS-1:0] alarm_en,
    input  logic                  snooze,
    input  logic                  dismiss,
    output logic [3:0]            h1,
    output logic [3:0]            h0,
    output logic [3:0]            m1,
    output logic [3:0]            m0,
    output logic [3:0]            s1,
    output logic [3:0]            s0,
    output logic                  sec_tick,
    output logic                  ringing,
    output logic                  snoozing,
    output logic [2:0]            ring_idx
);

    localparam int PW = $clog2(TICK_DIV);
    localparam int CW = $clog2(SNOOZE_MIN * 60 + 1);
    localparam int RW = $clog2(RING_SECS + 1);

    localparam logic [7:0] HR_MAX = (HOUR_24 != 0) ? 8'h23 : 8'h12;
    localparam logic [7:0] HR_MIN = (HOUR_24 != 0) ? 8'h00 : 8'h01;
    localparam logic [7:0] HR_RST = (HOUR_24 != 0) ? 8'h00 : 8'h12;

    logic [PW-1:0] presc;
    logic          run_mode;
    logic          adv;

    always_ff @(posedge clk) begin
        if (!rst_n || presc == PW'(TICK_DIV - 1))
            presc <= '0;
        else
            presc <= presc + 1'b1;
    end

    assign sec_tick = (presc == PW'(TICK_DIV - 1));
    assign run_mode = (set_field == SF_RUN) || (set_field > SF_A_MIN);
    assign adv      = sec_tick && run && run_mode;

    logic [7:0] ss_q, mm_q, hh_q;
    logic [7:0] ss_nxt_unused, mm_nxt, hh_nxt;
    logic       ss_carry, mm_carry, hr_carry_unused;
    logic       ss_clr, mm_inc, hh_inc;

    assign ss_clr = inc && (set_field == SF_T_MIN);
    // Manual minute/hour edits never ripple; only the running chain carries.
    assign mm_inc = (adv && ss_carry) || (inc && set_field == SF_T_MIN);
    assign hh_inc = (adv && ss_carry && mm_carry) || (inc && set_field == SF_T_HR);

    bcd_mod_counter #(.MAX_TENS(4'd5), .MAX_UNITS(4'd9), .MIN_VAL(8'h00), .RST_VAL(8'h00)) u_ss (
        .clk(clk), .rst_n(rst_n), .load(ss_clr), .load_val(8'h00), .inc(adv),
        .q(ss_q), .nxt(ss_nxt_unused), .carry(ss_carry)
    );

    bcd_mod_counter #(.MAX_TENS(4'd5), .MAX_UNITS(4'd9), .MIN_VAL(8'h00), .RST_VAL(8'h00)) u_mm (
        .clk(clk), .rst_n(rst_n), .load(1'b0), .load_val(8'h00), .inc(mm_inc),
        .q(mm_q), .nxt(mm_nxt), .carry(mm_carry)
    );

    bcd_mod_counter #(.MAX_TENS(HR_MAX[7:4]), .MAX_UNITS(HR_MAX[3:0]),
                      .MIN_VAL(HR_MIN), .RST_VAL(HR_RST)) u_hh (
        .clk(clk), .rst_n(rst_n), .load(1'b0), .load_val(8'h00), .inc(hh_inc),
        .q(hh_q), .nxt(hh_nxt), .carry(hr_carry_unused)
    );

    assign {h1, h0} = hh_q;
    assign {m1, m0} = mm_q;
    assign {s1, s0} = ss_q;

    logic [15:0] alarm_q [NUM_ALARMS];

    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_ALARMS; i++) begin
            if (!rst_n) begin
                alarm_q[i] <= 16'h0000;
            end else if (inc && alarm_sel == 3'(i)) begin
                if (set_field == SF_A_HR)
                    alarm_q[i][15:8] <= bcd_inc_wrap(alarm_q[i][15:8], HR_MAX, HR_MIN);
                else if (set_field == SF_A_MIN)
                    alarm_q[i][7:0] <= bcd_inc_wrap(alarm_q[i][7:0], 8'h59, 8'h00);
            end
        end
    end

    // Compare against the time as it will read after this tick's carry chain.
    logic [7:0] new_mm, new_hh;
    logic       hit, match;
    logic [2:0] hit_idx;

    assign new_mm = mm_inc ? mm_nxt : mm_q;
    assign new_hh = hh_inc ? hh_nxt : hh_q;

    always_comb begin
        hit     = 1'b0;
        hit_idx = 3'd0;
        for (int i = NUM_ALARMS - 1; i >= 0; i--) begin
            if (alarm_en[i] && alarm_q[i] == {new_hh, new_mm}) begin
                hit     = 1'b1;
                hit_idx = 3'(i);
            end
        end
    end

    assign match = hit && adv && ss_carry;

    ring_state_t   state;
    logic [RW-1:0] ring_cnt;
    logic [CW-1:0] snz_cnt;
    logic          en_cur;

    assign en_cur = |(alarm_en & (NUM_ALARMS'(1) << ring_idx));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            ringing  <= 1'b0;
            snoozing <= 1'b0;
            ring_idx <= 3'd0;
            ring_cnt <= '0;
            snz_cnt  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (match) begin
                        state    <= ST_RING;
                        ringing  <= 1'b1;
                        ring_idx <= hit_idx;
                        ring_cnt <= '0;
                    end
                end
                ST_RING: begin
                    if (dismiss || !en_cur) begin
                        state   <= ST_IDLE;
                        ringing <= 1'b0;
                    end else if (snooze) begin
                        state    <= ST_SNOOZE;
                        ringing  <= 1'b0;
                        snoozing <= 1'b1;
                        snz_cnt  <= CW'(SNOOZE_MIN * 60);
                    end else if (sec_tick) begin
                        if (ring_cnt == RW'(RING_SECS - 1)) begin
                            state   <= ST_IDLE;
                            ringing <= 1'b0;
                        end else begin
                            ring_cnt <= ring_cnt + 1'b1;
                        end
                    end
                end
                ST_SNOOZE: begin
                    if (dismiss || !en_cur) begin
                        state    <= ST_IDLE;
                        snoozing <= 1'b0;
                    end else if (sec_tick) begin
                        if (snz_cnt <= CW'(1)) begin
                            state    <= ST_RING;
                            ringing  <= 1'b1;
                            snoozing <= 1'b0;
                            ring_cnt <= '0;
                        end else begin
                            snz_cnt <= snz_cnt - 1'b1;
                        end
                    end
                end
                default: begin
                    state    <= ST_IDLE;
                    ringing  <= 1'b0;
                    snoozing <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alarm_clock_core.sv
// Scoreboard bench: 24-hour and 12-hour cores driven together against a seconds-level model.
module tb_alarm_clock_core;

    localparam int TD = 4;
    localparam int NA = 2;
    localparam int RS = 60;
    localparam int SM = 5;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          run = 1'b0;
    logic          inc = 1'b0;
    logic          snooze = 1'b0;
    logic          dismiss = 1'b0;
    logic [2:0]    set_field = 3'd0;
    logic [2:0]    alarm_sel = 3'd0;
    logic [NA-1:0] alarm_en = '0;

    logic [23:0] tm0, tm1;
    logic [1:0]  tick_o, ring_o, snz_o;
    logic [2:0]  idx0, idx1;

    alarm_clock_core #(.TICK_DIV(TD), .NUM_ALARMS(NA), .HOUR_24(1), .RING_SECS(RS), .SNOOZE_MIN(SM)) dut24 (
        .clk(clk), .rst_n(rst_n), .run(run), .set_field(set_field), .inc(inc),
        .alarm_sel(alarm_sel), .alarm_en(alarm_en), .snooze(snooze), .dismiss(dismiss),
        .h1(tm0[23:20]), .h0(tm0[19:16]), .m1(tm0[15:12]), .m0(tm0[11:8]),
        .s1(tm0[7:4]), .s0(tm0[3:0]), .sec_tick(tick_o[0]), .ringing(ring_o[0]),
        .snoozing(snz_o[0]), .ring_idx(idx0)
    );

    alarm_clock_core #(.TICK_DIV(TD), .NUM_ALARMS(NA), .HOUR_24(0), .RING_SECS(RS), .SNOOZE_MIN(SM)) dut12 (
        .clk(clk), .rst_n(rst_n), .run(run), .set_field(set_field), .inc(inc),
        .alarm_sel(alarm_sel), .alarm_en(alarm_en), .snooze(snooze), .dismiss(dismiss),
        .h1(tm1[23:20]), .h0(tm1[19:16]), .m1(tm1[15:12]), .m0(tm1[11:8]),
        .s1(tm1[7:4]), .s0(tm1[3:0]), .sec_tick(tick_o[1]), .ringing(ring_o[1]),
        .snoozing(snz_o[1]), .ring_idx(idx1)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [23:0] t;
        logic        tick;
        logic        ring;
        logic        snz;
        logic [2:0]  idx;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    int   n_chk = 0;
    int   n_pass = 0;

    task automatic chk(input string name, input int m, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp)
            n_pass++;
        else
            $display("FAIL %s %s: got %0h expected %0h at %0t", name, (m == 0) ? "h24" : "h12", act, exp, $time);
    endtask

    // Reference model: plain integer hours/minutes/seconds, one entry per DUT.
    int m_pc[2], m_hh[2], m_mm[2], m_ss[2];
    int m_ah[2][NA], m_am[2][NA];
    int m_st[2], m_rc[2], m_sc[2], m_ri[2];
    int ticks = 0;

    function automatic int next_hour(input int h, input int m);
        return (m == 0) ? (h + 1) % 24 : (h % 12) + 1;
    endfunction

    function automatic logic [7:0] to_bcd(input int v);
        return 8'(((v / 10) << 4) | (v % 10));
    endfunction

    task automatic model_step(input int m);
        bit   tick, hit;
        int   hi;
        exp_t e;
        if (!rst_n) begin
            m_pc[m] = 0; m_hh[m] = (m == 0) ? 0 : 12; m_mm[m] = 0; m_ss[m] = 0;
            for (int i = 0; i < NA; i++) begin m_ah[m][i] = 0; m_am[m][i] = 0; end
            m_st[m] = 0; m_rc[m] = 0; m_sc[m] = 0; m_ri[m] = 0;
        end else begin
            tick = (m_pc[m] == TD - 1);
            m_pc[m] = (m_pc[m] + 1) % TD;
            if (m == 0 && tick) ticks++;
            hit = 0; hi = 0;
            if (tick && run && (set_field == 3'd0 || set_field >= 3'd5)) begin
                m_ss[m]++;
                if (m_ss[m] == 60) begin
                    m_ss[m] = 0; m_mm[m]++;
                    if (m_mm[m] == 60) begin m_mm[m] = 0; m_hh[m] = next_hour(m_hh[m], m); end
                end
                if (m_ss[m] == 0)
                    for (int i = NA - 1; i >= 0; i--)
                        if (alarm_en[i] && m_ah[m][i] == m_hh[m] && m_am[m][i] == m_mm[m]) begin hit = 1; hi = i; end
            end
            if (inc) begin
                case (set_field)
                    3'd1: m_hh[m] = next_hour(m_hh[m], m);
                    3'd2: begin m_mm[m] = (m_mm[m] + 1) % 60; m_ss[m] = 0; end
                    3'd3: if (alarm_sel < NA) m_ah[m][alarm_sel] = next_hour(m_ah[m][alarm_sel], m);
                    3'd4: if (alarm_sel < NA) m_am[m][alarm_sel] = (m_am[m][alarm_sel] + 1) % 60;
                    default: ;
                endcase
            end
            case (m_st[m])
                0: if (hit) begin m_st[m] = 1; m_ri[m] = hi; m_rc[m] = 0; end
                1: if (dismiss || !alarm_en[m_ri[m]]) m_st[m] = 0;
                   else if (snooze) begin m_st[m] = 2; m_sc[m] = SM * 60; end
                   else if (tick) begin m_rc[m]++; if (m_rc[m] == RS) m_st[m] = 0; end
                default: if (dismiss || !alarm_en[m_ri[m]]) m_st[m] = 0;
                   else if (tick) begin m_sc[m]--; if (m_sc[m] == 0) begin m_st[m] = 1; m_rc[m] = 0; end end
            endcase
        end
        e.t    = {to_bcd(m_hh[m]), to_bcd(m_mm[m]), to_bcd(m_ss[m])};
        e.tick = (m_pc[m] == TD - 1);
        e.ring = (m_st[m] == 1);
        e.snz  = (m_st[m] == 2);
        e.idx  = 3'(m_ri[m]);
        if (m == 0) q0.push_back(e); else q1.push_back(e);
    endtask

    initial forever begin
        @(negedge clk);
        model_step(0);
        model_step(1);
    end

    task automatic compare(input int m, input exp_t e);
        chk("time", m, 32'((m == 0) ? tm0 : tm1), 32'(e.t));
        chk("sec_tick", m, 32'(tick_o[m]), 32'(e.tick));
        chk("ringing", m, 32'(ring_o[m]), 32'(e.ring));
        chk("snoozing", m, 32'(snz_o[m]), 32'(e.snz));
        if (e.ring || e.snz)
            chk("ring_idx", m, 32'((m == 0) ? idx0 : idx1), 32'(e.idx));
    endtask

    initial forever begin
        @(posedge clk);
        #1;
        if (q0.size() != 0) compare(0, q0.pop_front());
        if (q1.size() != 0) compare(1, q1.pop_front());
    end

    task automatic cyc(input int n = 1);
        repeat (n) begin @(posedge clk); #2; end
    endtask

    task automatic pulse_inc(input logic [2:0] sf, input int n);
        set_field = sf;
        for (int i = 0; i < n; i++) begin inc = 1'b1; cyc(); end
        inc = 1'b0;
        set_field = 3'd0;
    endtask

    task automatic set_hour(input int h);
        pulse_inc(3'd1, (h - m_hh[0] + 24) % 24);
    endtask

    task automatic set_min(input int mn);
        int n;
        n = (mn - m_mm[0] + 60) % 60;
        pulse_inc(3'd2, (n == 0) ? 60 : n);
    endtask

    task automatic set_alarm(input int sel, input int h, input int mn);
        alarm_sel = 3'(sel);
        pulse_inc(3'd3, (h - m_ah[0][sel] + 24) % 24);
        pulse_inc(3'd4, (mn - m_am[0][sel] + 60) % 60);
    endtask

    task automatic wait_ticks(input int n);
        int tgt, guard;
        tgt = ticks + n;
        guard = 0;
        while (ticks < tgt && guard < n * TD + 10) begin cyc(); guard++; end
        if (ticks < tgt) chk("tick_timeout", 0, 32'(ticks), 32'(tgt));
    endtask

    initial begin
        cyc(3);
        chk("rst_time", 0, 32'(tm0), 32'h000000);
        chk("rst_time", 1, 32'(tm1), 32'h120000);
        chk("rst_ring", 0, 32'(ring_o[0]), 32'd0);
        rst_n = 1'b1;
        run = 1'b1;

        wait_ticks(60);
        chk("one_minute", 0, 32'(tm0), 32'h000100);
        chk("one_minute", 1, 32'(tm1), 32'h120100);

        set_hour(23); set_min(59);
        wait_ticks(58);
        chk("preload", 0, 32'(tm0), 32'h235958);
        wait_ticks(2);
        chk("day_wrap", 0, 32'(tm0), 32'h000000);
        chk("day_wrap", 1, 32'(tm1), 32'h120000);

        set_min(59);
        wait_ticks(59);
        chk("pre_12_wrap", 1, 32'(tm1), 32'h125959);
        wait_ticks(1);
        chk("hour_12_wrap", 1, 32'(tm1), 32'h010000);

        set_alarm(1, 7, 30);
        alarm_en = 2'b10;
        set_hour(7); set_min(29);
        wait_ticks(59);
        chk("pre_alarm", 0, 32'(ring_o[0]), 32'd0);
        wait_ticks(1);
        chk("alarm_ring", 0, 32'(ring_o[0]), 32'd1);
        chk("alarm_idx", 0, 32'(idx0), 32'd1);
        wait_ticks(59);
        chk("ring_59", 0, 32'(ring_o[0]), 32'd1);
        wait_ticks(1);
        chk("ring_timeout", 0, 32'(ring_o[0]), 32'd0);

        set_min(29);
        wait_ticks(60);
        chk("ring_again", 0, 32'(ring_o[0]), 32'd1);
        snooze = 1'b1; cyc(); snooze = 1'b0;
        chk("snoozing", 0, 32'(snz_o[0]), 32'd1);
        wait_ticks(299);
        chk("snooze_299", 0, 32'(ring_o[0]), 32'd0);
        wait_ticks(1);
        chk("snooze_done", 0, 32'(ring_o[0]), 32'd1);
        dismiss = 1'b1; snooze = 1'b1; cyc(); dismiss = 1'b0; snooze = 1'b0;
        chk("dismiss_ring", 0, 32'(ring_o[0]), 32'd0);
        chk("dismiss_snz", 0, 32'(snz_o[0]), 32'd0);

        set_alarm(0, 6, 0); set_alarm(1, 6, 0);
        alarm_en = 2'b11;
        set_hour(5); set_min(59);
        wait_ticks(60);
        chk("tie_ring", 0, 32'(ring_o[0]), 32'd1);
        chk("tie_idx", 0, 32'(idx0), 32'd0);
        wait_ticks(3);
        alarm_en = 2'b10; cyc();
        chk("en_clear", 0, 32'(ring_o[0]), 32'd0);

        set_alarm(0, 10, 15);
        alarm_en = 2'b01;
        set_hour(10); set_min(14);
        wait_ticks(60);
        snooze = 1'b1; cyc(); snooze = 1'b0;
        wait_ticks(42);
        chk("pre_reset", 0, 32'(tm0), 32'h101542);
        chk("pre_reset_snz", 0, 32'(snz_o[0]), 32'd1);
        rst_n = 1'b0; cyc(); rst_n = 1'b1;
        chk("mid_reset", 0, 32'(tm0), 32'h000000);
        chk("mid_reset_snz", 0, 32'(snz_o[0]), 32'd0);
        set_hour(23); set_min(59);
        wait_ticks(60);
        chk("alarm_reset_val", 0, 32'(ring_o[0]), 32'd1);
        dismiss = 1'b1; cyc(); dismiss = 1'b0;

        set_alarm(0, 0, 2); set_alarm(1, 0, 3);
        alarm_en = 2'b11;
        for (int i = 0; i < 3000; i++) begin
            inc       = ($urandom_range(0, 99) < 5);
            set_field = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7)) : 3'd0;
            alarm_sel = 3'($urandom_range(0, 3));
            snooze    = ($urandom_range(0, 39) == 0);
            dismiss   = ($urandom_range(0, 79) == 0);
            run       = ($urandom_range(0, 7) != 0);
            if ($urandom_range(0, 199) == 0) alarm_en = 2'($urandom_range(0, 3));
            rst_n     = ($urandom_range(0, 999) != 0);
            cyc();
        end
        inc = 1'b0; snooze = 1'b0; dismiss = 1'b0; set_field = 3'd0; rst_n = 1'b1;
        cyc(3);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
